// File: rtl/lutram_fifo_if.sv
// Valid/ready handshake bundle for lutram_fifo: write side (in_*) and read side (out_*).
// The FIFO takes the slave view; the producer/consumer logic takes the master view.
interface lutram_fifo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/lutram_fifo.sv
// Single-clock FIFO on a generated array of 16x4 distributed RAMs (WIDTH/4 columns by
// DEPTH/16 banks) with a registered first-word-fall-through output stage.
module lutram_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    lutram_fifo_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BANKS = DEPTH / 16;
    localparam int COLS  = WIDTH / 4;

    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  ram_cnt_q, ram_cnt_d;
    logic                           out_valid_q, out_valid_d;
    logic [WIDTH-1:0]               out_data_q, out_data_d;
    logic                           push, pop, load;
    logic [AW-1:0]                  wr_bank, rd_bank;
    logic [BANKS-1:0]               wre;
    logic [BANKS-1:0][WIDTH-1:0]    bank_rd;
    logic [WIDTH-1:0]               rd_word;

    assign count        = ram_cnt_q + CW'(out_valid_q);
    assign bus.in_ready = count < CW'(DEPTH);
    assign almost_full  = count >= CW'(AF_LEVEL);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = out_valid_q && bus.out_ready;
    // The output register refills whenever it is empty or being drained this cycle.
    assign load = (ram_cnt_q != '0) && (!out_valid_q || bus.out_ready);

    assign wr_bank = wr_ptr_q >> 4;
    assign rd_bank = rd_ptr_q >> 4;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign wre[b] = push && (wr_bank == AW'(b));
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [3:0] mem [16];

            always_ff @(posedge clk) begin
                if (wre[b]) mem[wr_ptr_q[3:0]] <= bus.in_data[c*4 +: 4];
            end

            assign bank_rd[b][c*4 +: 4] = mem[rd_ptr_q[3:0]];
        end
    end

    always_comb begin
        rd_word = bank_rd[0];
        for (int b = 1; b < BANKS; b++) begin
            if (rd_bank == AW'(b)) rd_word = bank_rd[b];
        end
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ram_cnt_d   = ram_cnt_q + CW'(push) - CW'(load);
        out_data_d  = load ? rd_word : out_data_q;
        out_valid_d = load || (out_valid_q && !pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: doc/lutram_fifo.md
# lutram_fifo

Parametrised single-clock FIFO built on ECP5 distributed RAM (DPR16X4C slices), tiled in WIDTH/4 columns by DEPTH/16 banks, with per-bank write-enable decode and a registered first-word-fall-through output stage. It is the next-generation distributed-RAM test and timing block: it replaces fixed, hand-instanced 16x4 RAMs with a generated array and adds occupancy tracking and valid/ready flow control. Trellis timing fuzzers and the ECP5 example designs use it as a realistic LUTRAM load.

## Interface
- WIDTH, 8, data width; multiple of 4, range 4..64
- DEPTH, 32, total capacity in words; power of 2, range 16..256 (DEPTH/16 banks)
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH
- clk  in  1  single clock; all RAM writes and registers use the rising edge
- resetn  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  write data
- in_valid  in  1  write request
- in_ready  out  1  FIFO can accept a word this cycle
- out_data  out  WIDTH  head word (registered)
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts head word
- count  out  $clog2(DEPTH)+1  words held (RAM plus output register)
- almost_full  out  1  count >= AF_LEVEL

## Operation
- Storage: WIDTH/4 x DEPTH/16 DPR16X4C instances. Address low 4 bits drive WAD/RAD; upper bits select bank. Per-bank WRE = push AND (wr_ptr bank bits == bank index). Read data is muxed across banks by rd_ptr bank bits. RAM contents are not reset.
- push = in_valid && in_ready; writes in_data at wr_ptr; wr_ptr increments, wrapping DEPTH-1 -> 0.
- pop = out_valid && out_ready; consumes the output register.
- Internal ram_cnt (0..DEPTH) counts words in RAM not yet moved to the output register.
- load = ram_cnt != 0 && (!out_valid || out_ready). On load, the register captures the RAM word at rd_ptr, out_valid becomes 1, and rd_ptr increments with wrap.
- On pop without load, out_valid becomes 0 and out_data holds its last value.
- ram_cnt next = ram_cnt + push - load. count = ram_cnt + out_valid.
- in_ready = count < DEPTH (combinational from registers). No ready-through: when count == DEPTH, in_ready stays 0 even during a pop.
- in_valid while in_ready == 0 is ignored. out_ready while out_valid == 0 is ignored.
- almost_full = count >= AF_LEVEL (combinational from registers).

## Timing
- Reset (asynchronous, immediate): wr_ptr = 0, rd_ptr = 0, ram_cnt = 0, out_valid = 0, out_data = 0. This gives count = 0, in_ready = 1, and almost_full = 0 (AF_LEVEL >= 1).
- Reset asserted mid-operation discards all contents. The first push after deassertion lands at address 0.
- Write-to-read latency: a word pushed into an empty FIFO at edge E appears with out_valid = 1 after edge E+1. A word written at edge E is never read at edge E.
- Streaming throughput: with continuous push and pop, one word per cycle in steady state.
- Simultaneous push and pop at count == 1 with ram_cnt == 0: out_valid drops for one cycle, then the new word appears.
- Pointer wrap: at DEPTH-1 the pointer increments to 0 and bank select returns to bank 0.
- Full: count == DEPTH means ram_cnt == DEPTH-1 and out_valid == 1. Maximum storage is DEPTH words.
- Bank boundary: addresses 15 -> 16 switch WRE from bank 0 to bank 1 with no bubble.

## Test plan
- Reset, then push 0x11..0x15 at one word per cycle with out_ready = 0 -> out_valid rises one edge after the first push, out_data = 0x11, count = 5.
- Fill DEPTH = 32 words 0x00..0x1F with out_ready = 0 -> in_ready = 0 when count = 32; almost_full rises at count 30; a 33rd in_valid is ignored.
- From full, drain with out_ready = 1 -> 0x00..0x1F emerge in order, one per cycle; in_ready returns to 1 on the first cycle with count 31.
- Stream 100 words with in_valid and out_ready both tied high -> all outputs match input order across pointer wrap and bank 0/1 switches; count is stable at 1 or 2.
- Assert resetn = 0 asynchronously mid-stream at count = 7 -> out_valid = 0, count = 0 and out_data = 0 immediately; after release, the next word pushed is the first word read.
- Random valid/ready stimulus with WIDTH = 12 and DEPTH = 64 against a scoreboard -> no loss, duplication or reordering.
